tile_rect_fill: RTL and testbench

- Hardware rectangle-fill engine that sits directly upstream of the tile video unit and drives its VRAM write port.
- Takes a rectangle in tile coordinates plus a 2-bit palette index from the CPU bus.
- Packing: VRAM holds 4 tiles per byte, tile slot s in bits [2s+1:2s].
- Fills the rectangle by read-modify-write of VRAM bytes, so the CPU does not have to pack 2-bit fields itself.

---
 rtl/tile_rect_fill.sv | 278 +++++++++++++++++++++++++++
 tb/tb_tile_rect_fill.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_rect_fill.sv
// tile_rect_fill: rectangle-fill engine for a 2-bit-per-tile VRAM.
//
// The engine takes a rectangle in tile coordinates plus a palette index,
// clips it to the TILES_H x TILES_V map, and writes every covered tile by
// read-modify-write of the packed VRAM bytes. Each byte holds four tiles:
// tile slot s lives in bits [2s+1:2s].
//
// Optional feature, enabled by defining TILE_FILL_FAST_EN:
//   whole aligned bytes (slot 0 with at least four tiles left in the row)
//   are written in one cycle without a read.
//
// Per-tile sequence without the fast path:
//   RD : present the byte address (read data returns in the next cycle)
//   WR : merge the 2-bit color into the returned byte and write it back
// An empty or fully clipped request spends one busy cycle in EMPTY, then
// pulses done from FINISH. done is high only while the FSM is in FINISH.
module tile_rect_fill #(
  parameter int TILES_H    = 28,
  parameter int TILES_V    = 18,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4:0]            x0,
  input  logic [4:0]            y0,
  input  logic [5:0]            w,
  input  logic [4:0]            h,
  input  logic [1:0]            color,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [7:0]            vram_wdata,
  output logic                  vram_wenable,
  input  logic [7:0]            vram_rdata
);

  // Coordinate arithmetic is 7 bits wide: x0 + w can reach 31 + 63, so
  // clipping never wraps.
  localparam int CW    = 7;
  // Tile index width; the two low bits select the slot within a byte.
  localparam int IDX_W = ADDR_WIDTH + 2;

  typedef logic [CW-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_EMPTY,
    ST_FINISH
`ifdef TILE_FILL_FAST_EN
    ,
    ST_FAST
`endif
  } state_t;

  state_t state;

  // Latched operation: clipped column range [x_lo, x_end), row limit
  // y_end, and the fill color.
  coord_t     x_lo;
  coord_t     x_end;
  coord_t     y_end;
  logic [1:0] color_q;

  // Current tile position and the slot of the byte being processed.
  coord_t     cx;
  coord_t     cy;
  logic [1:0] slot_q;

  // Linear tile index y*TILES_H + x.
  function automatic logic [IDX_W-1:0] tile_index(coord_t x, coord_t y);
    return IDX_W'(y) * IDX_W'(TILES_H) + IDX_W'(x);
  endfunction

  // ---------------------------------------------------------------------
  // Request clipping, evaluated on the live request inputs.
  // ---------------------------------------------------------------------
  coord_t req_x;
  coord_t req_y;
  coord_t req_w;
  coord_t req_h;
  coord_t room_x;
  coord_t room_y;
  coord_t clip_w;
  coord_t clip_h;
  logic   req_empty;

  assign req_x  = CW'(x0);
  assign req_y  = CW'(y0);
  assign req_w  = CW'(w);
  assign req_h  = CW'(h);
  // room_* wraps when the origin is off the map; req_empty covers that case.
  assign room_x = CW'(TILES_H) - req_x;
  assign room_y = CW'(TILES_V) - req_y;
  assign clip_w = (req_w < room_x) ? req_w : room_x;
  assign clip_h = (req_h < room_y) ? req_h : room_y;

  assign req_empty = (req_x >= CW'(TILES_H)) || (req_y >= CW'(TILES_V)) ||
                     (clip_w == '0) || (clip_h == '0);

  // ---------------------------------------------------------------------
  // Position advance: step past the tiles just written, wrap to the next
  // row at the clipped right edge.
  // ---------------------------------------------------------------------
  coord_t step;
  coord_t adv_x;
  coord_t next_x;
  coord_t next_y;
  logic   more;

  // Next tile after the current write; more is low once the last row ends.
  // NOTE: every signal driven here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    step = CW'(1);
`ifdef TILE_FILL_FAST_EN
    if (state == ST_FAST) step = CW'(4);
`endif
    adv_x  = cx + step;
    next_x = adv_x;
    next_y = cy;
    if (adv_x >= x_end) begin
      next_x = x_lo;
      next_y = cy + CW'(1);
    end
    more = (next_y < y_end);
  end

  // ---------------------------------------------------------------------
  // Entry into a tile: from IDLE the request origin, otherwise the
  // advanced position. Decides between a read-modify-write and, when the
  // fast path exists, a whole-byte write.
  // ---------------------------------------------------------------------
  coord_t           ent_x;
  coord_t           ent_y;
  logic [IDX_W-1:0] ent_idx;
  logic             ent_fast;
  state_t           ent_state;
`ifdef TILE_FILL_FAST_EN
  coord_t           ent_end;
`endif

  // Address, slot and next state for the tile about to be processed.
  always_comb begin
    if (state == ST_IDLE) begin
      ent_x = req_x;
      ent_y = req_y;
    end else begin
      ent_x = next_x;
      ent_y = next_y;
    end
    ent_idx   = tile_index(ent_x, ent_y);
    ent_fast  = 1'b0;
    ent_state = ST_RD;
`ifdef TILE_FILL_FAST_EN
    ent_end = (state == ST_IDLE) ? (req_x + clip_w) : x_end;
    // Rows start on byte boundaries, so slot 0 plus four tiles left in the
    // row means the whole byte belongs to the rectangle.
    if ((ent_idx[1:0] == 2'b00) && ((ent_end - ent_x) >= CW'(4))) begin
      ent_fast  = 1'b1;
      ent_state = ST_FAST;
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered busy/done/address/write-enable.
  // ---------------------------------------------------------------------
  // Sequence tiles and drive the registered outputs.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      vram_wenable <= 1'b0;
      vram_addr    <= '0;
      x_lo         <= '0;
      x_end        <= '0;
      y_end        <= '0;
      color_q      <= '0;
      cx           <= '0;
      cy           <= '0;
      slot_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            color_q <= color;
            x_lo    <= req_x;
            x_end   <= req_x + clip_w;
            y_end   <= req_y + clip_h;
            busy    <= 1'b1;
            if (req_empty) begin
              state <= ST_EMPTY;
            end else begin
              cx           <= ent_x;
              cy           <= ent_y;
              vram_addr    <= ent_idx[IDX_W-1:2];
              slot_q       <= ent_idx[1:0];
              state        <= ent_state;
              vram_wenable <= ent_fast;
            end
          end
        end

        // Empty request: one busy cycle, then the completion pulse.
        ST_EMPTY: begin
          state <= ST_FINISH;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        // Address is on the bus; the byte comes back next cycle.
        ST_RD: begin
          state        <= ST_WR;
          vram_wenable <= 1'b1;
        end

        ST_WR
`ifdef TILE_FILL_FAST_EN
        , ST_FAST
`endif
        : begin
          vram_wenable <= 1'b0;
          if (more) begin
            cx           <= ent_x;
            cy           <= ent_y;
            vram_addr    <= ent_idx[IDX_W-1:2];
            slot_q       <= ent_idx[1:0];
            state        <= ent_state;
            vram_wenable <= ent_fast;
          end else begin
            state <= ST_FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        // done is high for exactly this cycle; start is not sampled here.
        ST_FINISH: begin
          state <= ST_IDLE;
        end

        default: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          vram_wenable <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Write data: the read byte arrives during WR, so the merge is
  // combinational from vram_rdata. Zero whenever no write is in progress.
  // ---------------------------------------------------------------------
  logic [7:0] merged;

  // Replace the addressed 2-bit field with the fill color.
  always_comb begin
    merged                      = vram_rdata;
    merged[{slot_q, 1'b0} +: 2] = color_q;
    vram_wdata                  = '0;
    case (state)
      ST_WR:   vram_wdata = merged;
`ifdef TILE_FILL_FAST_EN
      ST_FAST: vram_wdata = {4{color_q}};
`endif
      default: vram_wdata = '0;
    endcase
  end

endmodule

// File: tb/tb_tile_rect_fill.sv
// Bench for tile_rect_fill. A VRAM with one-cycle read latency surrounds
// the design. A tile-level model turns each request into a per-cycle list
// of expected busy/done/write activity, which one negedge process compares
// against the design. Directed requests also carry hand-computed literal
// expectations.
module tb_tile_rect_fill;

  localparam int TILES_H = 28;
  localparam int TILES_V = 18;
  localparam int AW      = 7;
`ifdef TILE_FILL_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [4:0]    x0;
  logic [4:0]    y0;
  logic [5:0]    w;
  logic [4:0]    h;
  logic [1:0]    color;
  logic          busy;
  logic          done;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_wdata;
  logic          vram_wenable;
  logic [7:0]    vram_rdata;

  tile_rect_fill #(
    .TILES_H   (TILES_H),
    .TILES_V   (TILES_V),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .x0          (x0),
    .y0          (y0),
    .w           (w),
    .h           (h),
    .color       (color),
    .busy        (busy),
    .done        (done),
    .vram_addr   (vram_addr),
    .vram_wdata  (vram_wdata),
    .vram_wenable(vram_wenable),
    .vram_rdata  (vram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Starting VRAM image: byte 5 = FF, a scrambled band in the middle.
  function automatic logic [7:0] init_byte(input int i);
    if (i == 5) return 8'hFF;
    if (i >= 30 && i <= 120) return 8'(i * 37 + 11);
    return 8'h00;
  endfunction

  // VRAM: synchronous write, read data valid the cycle after the address.
  logic       mem_init;
  logic [7:0] vram [128];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) vram[i] <= init_byte(i);
      vram_rdata <= 8'h00;
    end else begin
      if (vram_wenable === 1'b1) vram[vram_addr] <= vram_wdata;
      vram_rdata <= vram[vram_addr];
    end
  end

  // Expected activity for one clock cycle.
  typedef struct {
    bit busy;
    bit done;
    bit wen;
    int addr;
    int data;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] gold [128];

  function automatic exp_t mk(input bit b, input bit d, input bit we, input int a, input int dt);
    exp_t e;
    e.busy = b;
    e.done = d;
    e.wen  = we;
    e.addr = a;
    e.data = dt;
    return e;
  endfunction

  // Tile-level model: clip, walk the tiles in raster order, and list what
  // every cycle from the start cycle to the done pulse must show.
  task automatic plan_op(input int px, input int py, input int pw, input int ph, input int pc);
    logic [7:0] img [128];
    int ew, eh, x, idx, a, s;
    img = gold;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    ew = (px >= TILES_H) ? 0 : ((pw < TILES_H - px) ? pw : TILES_H - px);
    eh = (py >= TILES_V) ? 0 : ((ph < TILES_V - py) ? ph : TILES_V - py);
    if (ew == 0 || eh == 0) begin
      exp_q.push_back(mk(1, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 1, 0, 0, 0));
      return;
    end
    for (int y = py; y < py + eh; y++) begin
      x = px;
      while (x < px + ew) begin
        idx = y * TILES_H + x;
        a   = idx / 4;
        s   = idx % 4;
        if (FAST && s == 0 && (px + ew - x) >= 4) begin
          img[a] = {4{pc[1:0]}};
          exp_q.push_back(mk(1, 0, 1, a, int'(img[a])));
          x += 4;
        end else begin
          exp_q.push_back(mk(1, 0, 0, 0, 0));
          img[a] = (img[a] & ~(8'd3 << (2 * s))) | (8'(pc & 3) << (2 * s));
          exp_q.push_back(mk(1, 0, 1, a, int'(img[a])));
          x += 1;
        end
      end
    end
    exp_q.push_back(mk(0, 1, 0, 0, 0));
  endtask

  // Activity counters and write log, owned by the compare process.
  int         busy_cnt = 0;
  int         done_cnt = 0;
  int         wr_cnt   = 0;
  int         log_a [$];
  logic [7:0] log_d [$];

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (mem_init) for (int i = 0; i < 128; i++) gold[i] = init_byte(i);
    if (!rst_n) begin
      exp_q.delete();
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_wen", 32'(vram_wenable), 0);
    end else begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(0, 0, 0, 0, 0);
      check("busy", 32'(busy), 32'(e.busy));
      check("done", 32'(done), 32'(e.done));
      check("wen", 32'(vram_wenable), 32'(e.wen));
      if (e.wen) begin
        check("addr", 32'(vram_addr), e.addr);
        check("wdata", 32'(vram_wdata), e.data);
        gold[e.addr] = 8'(e.data);
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (vram_wenable === 1'b1) begin
        wr_cnt++;
        log_a.push_back(int'(vram_addr));
        log_d.push_back(vram_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; called one step after a rising edge.
  task automatic start_op(input int px, input int py, input int pw, input int ph, input int pc);
    x0    = 5'(px);
    y0    = 5'(py);
    w     = 6'(pw);
    h     = 5'(ph);
    color = 2'(pc);
    start = 1'b1;
    plan_op(px, py, pw, ph, pc);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, exp_q.size(), 0);
  endtask

  int bb, db, wb, lb;
  task automatic snap();
    bb = busy_cnt;
    db = done_cnt;
    wb = wr_cnt;
    lb = log_a.size();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    x0       = '0;
    y0       = '0;
    w        = '0;
    h        = '0;
    color    = '0;
    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wen", 32'(vram_wenable), 0);
    check("rst_addr", 32'(vram_addr), 0);
    check("rst_wdata", 32'(vram_wdata), 0);
    rst_n = 1'b1;
    tick();
    tick();

    // Single tile: byte 0 = 00, column 1, color 3 -> one write of 0C.
    snap();
    start_op(1, 0, 1, 1, 3);
    wait_done("single");
    check("single_writes", wr_cnt - wb, 1);
    check("single_addr", log_a[lb], 0);
    check("single_data", 32'(log_d[lb]), 32'h0C);
    check("single_busy", busy_cnt - bb, 2);
    check("single_done", done_cnt - db, 1);
    check("single_byte0", 32'(vram[0]), 32'h0C);

    // Merge into byte 5 = FF: columns 20,21 color 0 -> FC then F0.
    snap();
    start_op(20, 0, 2, 1, 0);
    wait_done("merge");
    check("merge_writes", wr_cnt - wb, 2);
    check("merge_addr0", log_a[lb], 5);
    check("merge_data0", 32'(log_d[lb]), 32'hFC);
    check("merge_addr1", log_a[lb+1], 5);
    check("merge_data1", 32'(log_d[lb+1]), 32'hF0);
    check("merge_byte5", 32'(vram[5]), 32'hF0);

    // Clipping at the bottom-right corner: tiles 502, 503 only.
    snap();
    start_op(26, 17, 10, 5, 2);
    wait_done("clip");
    check("clip_writes", wr_cnt - wb, 2);
    check("clip_busy", busy_cnt - bb, 4);
    check("clip_addr0", log_a[lb], 125);
    check("clip_addr1", log_a[lb+1], 125);
    check("clip_data0", 32'(log_d[lb]), 32'h20);
    check("clip_data1", 32'(log_d[lb+1]), 32'hA0);

    // Empty requests: zero width, column off the map, row off the map.
    snap();
    start_op(3, 3, 0, 2, 1);
    wait_done("empty_w0");
    check("empty_w0_writes", wr_cnt - wb, 0);
    check("empty_w0_busy", busy_cnt - bb, 1);
    check("empty_w0_done", done_cnt - db, 1);
    snap();
    start_op(28, 0, 4, 4, 1);
    wait_done("empty_x28");
    check("empty_x28_writes", wr_cnt - wb, 0);
    check("empty_x28_busy", busy_cnt - bb, 1);
    check("empty_x28_done", done_cnt - db, 1);
    snap();
    start_op(0, 18, 4, 4, 1);
    wait_done("empty_y18");
    check("empty_y18_writes", wr_cnt - wb, 0);
    check("empty_y18_busy", busy_cnt - bb, 1);

    // Full row 1, color 1: bytes 7..13 become 55.
    snap();
    start_op(0, 1, 28, 1, 1);
    wait_done("row");
    check("row_writes", wr_cnt - wb, FAST ? 7 : 28);
    check("row_busy", busy_cnt - bb, FAST ? 7 : 56);
    check("row_first_addr", log_a[lb], 7);
    for (int i = 7; i <= 13; i++) check("row_byte", 32'(vram[i]), 32'h55);

    // Two rows with unaligned ends over pre-filled bytes.
    snap();
    start_op(2, 5, 13, 2, 3);
    wait_done("mixed");
    check("mixed_writes", wr_cnt - wb, FAST ? 14 : 26);
    check("mixed_busy", busy_cnt - bb, FAST ? 24 : 52);

    // A second start while busy must not disturb the running fill.
    snap();
    start_op(4, 2, 8, 3, 2);
    repeat (2) tick();
    x0    = 5'd0;
    y0    = 5'd0;
    w     = 6'd28;
    h     = 5'd18;
    color = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("midstart");
    check("midstart_writes", wr_cnt - wb, FAST ? 6 : 24);
    check("midstart_busy", busy_cnt - bb, FAST ? 6 : 48);
    check("midstart_done", done_cnt - db, 1);

    // A start presented during the done cycle is ignored.
    snap();
    start_op(10, 8, 3, 1, 1);
    n = 0;
    while (exp_q.size() != 1 && n < 100) begin
      tick();
      n++;
    end
    check("finish_wait", exp_q.size(), 1);
    x0    = 5'd0;
    y0    = 5'd0;
    w     = 6'd4;
    h     = 5'd1;
    color = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("finstart");
    repeat (4) tick();
    check("finstart_busy", busy_cnt - bb, 6);
    check("finstart_writes", wr_cnt - wb, 3);
    check("finstart_done", done_cnt - db, 1);

    // Reset in the middle of a fill aborts it with no done pulse.
    snap();
    start_op(0, 4, 28, 4, 3);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_wen", 32'(vram_wenable), 0);
    check("abort_done", 32'(done), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("abort_no_done", done_cnt - db, 0);

    // A fresh request after the reset completes normally.
    snap();
    start_op(8, 10, 5, 2, 1);
    wait_done("post_reset");
    check("post_reset_done", done_cnt - db, 1);
    check("post_reset_writes", wr_cnt - wb, FAST ? 4 : 10);
    check("post_reset_busy", busy_cnt - bb, FAST ? 6 : 20);

    // Whole VRAM must equal the model image.
    tick();
    for (int i = 0; i < 126; i++) check("final_vram", 32'(vram[i]), 32'(gold[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
